// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// serial_add_ctrl : bit-serial a+b+cin, one full-adder slice, valid/ready I/O
// Rev 1.0
// ============================================================================
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_sum;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;

  logic w_s;
  logic w_c;
  logic w_accept;
  logic w_last;

  assign w_s      = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_last   = (r_state == S_RUN) && (r_cnt == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Partial sum builds in r_acc so the visible result only changes when a
  // complete answer is published on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_acc   <= {w_s, r_acc[WIDTH-1:1]};
      r_carry <= w_c;
      if (w_last) begin
        r_sum  <= {w_s, r_acc[WIDTH-1:1]};
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end else begin
        r_cnt  <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2 to 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  addend A, unsigned or two's-complement.
REQ-007 b  input  WIDTH  addend B.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  result is available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  WIDTH  result bits.
REQ-012 cout  output  1  carry out of the MSB.
REQ-013 ovf  output  1  signed overflow, defined as carry into MSB XOR carry out of MSB.
REQ-014 busy  output  1  high in RUN.

Function
REQ-015 The block SHALL compute a+b+cin bit-serially, using one full-adder slice (sum = x^y^c, carry = majority) and a 1-bit carry register, over WIDTH cycles.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-017 IDLE: in_ready=1, out_valid=0, busy=0; on an edge with in_valid=1, the block SHALL load a and b into shift registers, load carry<=cin, clear the bit counter to 0, and go to RUN.
REQ-018 RUN: in_ready=0, busy=1; each edge SHALL add the shift-register LSBs plus carry, shift the sum bit into the result register from the MSB side, shift the operands right by one, update carry, and increment the counter.
REQ-019 On the edge that processes bit WIDTH-1, the block SHALL latch ovf = (carry into bit WIDTH-1) XOR (carry out), set cout to the final carry, and go to DONE.
REQ-020 Latency: out_valid SHALL go high exactly WIDTH rising edges after the accepting edge.
REQ-021 DONE: out_valid=1, in_ready=0; sum, cout and ovf SHALL stay stable until an edge with out_ready=1 occurs, after which the FSM returns to IDLE.
REQ-022 in_valid, a, b and cin SHALL be ignored outside IDLE; a new request is never accepted while in RUN or DONE.
REQ-023 Accept and complete SHALL NOT overlap: after the DONE handshake, in_ready rises on the following cycle, so back-to-back throughput is one result per WIDTH+2 cycles with out_ready held at 1.
REQ-024 out_ready asserted outside DONE SHALL have no effect.
REQ-025 sum, cout and ovf SHALL keep their last values in IDLE and RUN; they SHALL be valid only while out_valid=1.
REQ-026 Wrap-around: the counter SHALL be ceil(log2(WIDTH))+1 bits wide and is compared against WIDTH-1; it does not count past WIDTH-1.

Reset
REQ-027 While rst=1, the block SHALL immediately, without waiting for clk, force: state=IDLE; in_ready=1; out_valid=0; busy=0; sum=0; cout=0; ovf=0; carry=0; counter=0.
REQ-028 If rst asserts in RUN or DONE, any in-flight result SHALL be discarded with no partial out_valid pulse.
REQ-029 On the first edge after rst deasserts, the block SHALL be able to accept a request.

Verification (WIDTH=8)
REQ-030 Stimulus: a=0x5A, b=0x33, cin=0 -> response: out_valid after 8 edges; sum=0x8D; cout=0; ovf=1.
REQ-031 Stimulus: a=0xFF, b=0x01, cin=0 -> response: sum=0x00; cout=1; ovf=0.
REQ-032 Stimulus: a=0x7F, b=0x00, cin=1 -> response: sum=0x80; cout=0; ovf=1.
REQ-033 Backpressure: out_ready held at 0 for 5 cycles in DONE -> sum, cout and ovf stay stable and in_ready stays 0; the handshake on the 6th cycle returns the FSM to IDLE. A second in_valid pulse (a=0x01, b=0x01) during RUN -> ignored; the first result is unchanged.
REQ-034 Reset mid-operation: rst pulsed at bit 4 of RUN -> outputs immediately take their reset values; out_valid never rises; the next request (a=0x10, b=0x20, cin=0) yields sum=0x30, cout=0, ovf=0.
REQ-035 Back-to-back: out_ready tied to 1 with 3 queued requests -> out_valid pulses spaced 10 cycles apart, and every result matches a+b+cin.
